clock_divider: RTL and testbench
================================

Name: clock_divider

Overview:
- Programmable integer clock divider.
- Derives output_clk from reference_clk by a run-time ratio of 2–63; used to generate slow peripheral clocks (e.g. UART bit/sample clocks).
- When disabled, or when the ratio is 0 or 1, the reference clock passes straight through.
- Ratio changes take effect only at output period boundaries, so no runt pulses occur.

Parameters:
- RATIO_W, 6, width of division_ratio and of internal counters.

Ports:
- reference_clk  input  1  source clock; all sequential logic on its rising edge (plus the falling edge with the optional feature).
- reset  input  1  asynchronous, active-high reset.
- clk_divider_enable  input  1  1 = divide, 0 = bypass.
- division_ratio  input  RATIO_W  requested divide ratio N.
- output_clk  output  1  divided clock, or reference_clk in bypass.

Behaviour:
- Interface: one clock (reference_clk); reset is asynchronous and active-high.
- Reset values: div_q=0, cnt=0, ratio_q=0. output_clk follows the bypass mux, so it equals reference_clk during reset.
- Mode definition: active = clk_divider_enable && ratio_q >= 2.
  - Not active: output_clk = reference_clk (combinational mux).
  - Active: output_clk = div_q.
- Phase lengths: H = ceil(N/2) high cycles, L = floor(N/2) low cycles, period exactly N reference cycles.
  - N=2 gives 1/1; N=3 gives 2/1; N=5 gives 3/2.
- ratio_q loading:
  - Loaded from division_ratio on every rising edge while not active.
  - When active, loaded only on the edge that ends a high phase, which is the output falling edge and period boundary.
  - Mid-period ratio changes are ignored until that boundary.
- Counting, each rising edge while enable=1 and ratio_q>=2:
  - div_q=0 and cnt==L-1: set div_q=1, cnt=0.
  - div_q=1 and cnt==H-1: set div_q=0, cnt=0, reload ratio_q.
  - Otherwise: cnt=cnt+1.
- First period after entering active mode starts with the low phase. The first rising output edge follows L reference edges after the edge where active first becomes true.
- New ratio of 0 or 1 loaded at a boundary: mode drops to bypass on the next cycle.
- Enable deasserted: synchronously clear div_q and cnt on the next rising edge; output switches to bypass immediately (combinational).
- Enable reasserted: restart from the low phase with cnt=0.
- Reset mid-operation: immediate return to reset values and bypass output.
- Glitch-free switching between bypass and divided clock is not required. Only ratio changes within active mode must be glitch-free.

Optional Feature:
- Macro: CLOCK_DIVIDER_ODD_DUTY50_EN.
- Defined:
  - For odd N>=3, a falling-edge flop samples div_q.
  - output_clk = div_q AND neg_q, extending the low phase by half a cycle.
  - High time becomes exactly N/2 reference periods; period is unchanged.
  - Even N behaviour is unchanged.
- Undefined: odd N duty is ceil(N/2)/N as specified above. No falling-edge logic is present.

Decomposition:
- Shared package clock_divider_pkg holds:
  - RATIO_W;
  - constant MIN_DIV_RATIO = 2;
  - function computing H/L from N.
- One sub-module, clock_divider_mux: the bypass/divided output mux, kept as a separate cell so synthesis can map it to a clock-mux library cell.

Test Plan:
- Reset: assert reset with enable=0, ratio=0 -> output_clk tracks reference_clk (40 ps period); releasing reset keeps bypass.
- Enable=1, ratio=5 -> after 2 low cycles, output repeats 3 cycles high / 2 low; period 200 ps.
- Ratio changes 5->3 mid high phase -> current 5-period completes, then 2 high / 1 low (120 ps period); no pulse shorter than 1 reference cycle.
- Ratio 3->8, then 8->6 -> 4/4 (320 ps) then 3/3 (240 ps), each switch at a falling output edge.
- Ratio set to 1 or 0 while enabled -> bypass after the current period ends. Enable dropped mid-period -> immediate bypass; re-enable restarts with the low phase.
- With CLOCK_DIVIDER_ODD_DUTY50_EN, ratio=5 -> high 100 ps, low 100 ps; ratio=6 -> unchanged 3/3.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared constants and phase-length helper for the programmable clock divider.
package clock_divider_pkg;

  localparam int RATIO_W       = 6;
  localparam int MIN_DIV_RATIO = 2;

  typedef struct packed {
    int unsigned high;
    int unsigned low;
  } phase_len_t;

  // High phase gets the extra cycle for odd ratios: H = ceil(N/2), L = floor(N/2).
  function automatic phase_len_t phase_len(input int unsigned n);
    phase_len_t p;
    p.high = (n + 1) / 2;
    p.low  = n / 2;
    return p;
  endfunction

endpackage

// File: rtl/clock_divider_mux.sv
// Bypass/divided output select, isolated so synthesis can map it to a clock-mux cell.
module clock_divider_mux
  import clock_divider_pkg::*;
(
  input  logic sel,
  input  logic bypass_clk,
  input  logic divided_clk,
  output logic output_clk
);

  assign output_clk = sel ? divided_clk : bypass_clk;

endmodule

// File: rtl/clock_divider.sv
// Programmable integer clock divider (ratio 2..2^RATIO_W-1) with reference-clock bypass.
// Optional CLOCK_DIVIDER_ODD_DUTY50_EN adds a falling-edge flop for 50% duty on odd ratios.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int RATIO_W = clock_divider_pkg::RATIO_W
) (
  input  logic               reference_clk,
  input  logic               reset,
  input  logic               clk_divider_enable,
  input  logic [RATIO_W-1:0] division_ratio,
  output logic               output_clk
);

  logic [RATIO_W-1:0] ratio_q;
  logic [RATIO_W-1:0] cnt;
  logic [RATIO_W-1:0] h_len;
  logic [RATIO_W-1:0] l_len;
  logic               div_q;
  logic               active;
  logic               divided_clk;
  phase_len_t         ph;

  assign ph     = phase_len(32'(ratio_q));
  assign h_len  = RATIO_W'(ph.high);
  assign l_len  = RATIO_W'(ph.low);
  assign active = clk_divider_enable && (ratio_q >= RATIO_W'(MIN_DIV_RATIO));

  // ratio_q is only reloaded at the end of a high phase, so a period never gets cut short.
  always_ff @(posedge reference_clk or posedge reset) begin
    if (reset) begin
      ratio_q <= '0;
      cnt     <= '0;
      div_q   <= 1'b0;
    end else if (!active) begin
      ratio_q <= division_ratio;
      cnt     <= '0;
      div_q   <= 1'b0;
    end else if (!div_q) begin
      if (cnt == l_len - RATIO_W'(1)) begin
        div_q <= 1'b1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + RATIO_W'(1);
      end
    end else begin
      if (cnt == h_len - RATIO_W'(1)) begin
        div_q   <= 1'b0;
        cnt     <= '0;
        ratio_q <= division_ratio;
      end else begin
        cnt <= cnt + RATIO_W'(1);
      end
    end
  end

`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
  logic neg_q;

  // Delaying the rise by half a reference cycle trims the high phase to exactly N/2.
  always_ff @(negedge reference_clk or posedge reset) begin
    if (reset) neg_q <= 1'b0;
    else       neg_q <= div_q;
  end

  assign divided_clk = ratio_q[0] ? (div_q & neg_q) : div_q;
`else
  assign divided_clk = div_q;
`endif

  clock_divider_mux u_mux (
    .sel         (active),
    .bypass_clk  (reference_clk),
    .divided_clk (divided_clk),
    .output_clk  (output_clk)
  );

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: per-half-cycle waveform compare against a
// period-position reference model, plus measured period/high-time checks.
`timescale 1ps/1ps
module tb_clock_divider;

  logic       reference_clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_divider_enable = 1'b0;
  logic [5:0] division_ratio = '0;
  logic       output_clk;

  int  checks = 0;
  int  errors = 0;
  int  m_ratio = 0;
  int  m_pos = 0;
  time last_rise = 0, prev_rise = 0, last_high = 0;

  clock_divider dut (
    .reference_clk      (reference_clk),
    .reset              (reset),
    .clk_divider_enable (clk_divider_enable),
    .division_ratio     (division_ratio),
    .output_clk         (output_clk)
  );

  always #20 reference_clk = ~reference_clk;

  always @(posedge output_clk) begin
    prev_rise = last_rise;
    last_rise = $time;
  end
  always @(negedge output_clk) last_high = $time - last_rise;

  // Model: a period of N cycles is L low then H high; N is sampled at each period start.
  function automatic bit model_out(input bit hi_half);
    bit h;
    if (reset || !(clk_divider_enable && m_ratio >= 2)) return hi_half;
    h = (m_pos >= m_ratio / 2);
`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
    if (hi_half && (m_ratio % 2 == 1) && m_pos == m_ratio / 2) h = 1'b0;
`endif
    return h;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_ratio = 0; m_pos = 0;
    end else if (!clk_divider_enable || m_ratio < 2) begin
      m_ratio = int'(division_ratio); m_pos = 0;
    end else begin
      m_pos++;
      if (m_pos == m_ratio) begin
        m_pos = 0;
        m_ratio = int'(division_ratio);
      end
    end
  endtask

  // One reference cycle starting at a falling edge: drive, sample low half, edge, sample high half.
  task automatic tick(input bit e, input int r, output logic [1:0] obs, output logic [1:0] exp);
    clk_divider_enable = e;
    division_ratio = 6'(r);
    #10;
    obs[0] = output_clk; exp[0] = model_out(1'b0);
    @(posedge reference_clk);
    model_edge();
    #10;
    obs[1] = output_clk; exp[1] = model_out(1'b1);
    @(negedge reference_clk);
  endtask

  task automatic test_reset();
    logic [1:0] o, x;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 0, o, x); checks++;
      if (o !== 2'b10) begin errors++; $display("FAIL reset_bypass cyc %0d got %b want 10", i, o); end
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 0, o, x); checks++;
      if (o !== x) begin errors++; $display("FAIL post_reset cyc %0d got %b want %b", i, o, x); end
    end
  endtask

  task automatic test_ratio5();
    logic [1:0] o, x;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 5, o, x); checks++;
      if (o !== x) begin errors++; $display("FAIL ratio5 cyc %0d got %b want %b", i, o, x); end
    end
    checks++;
    if (last_rise - prev_rise !== 200) begin errors++; $display("FAIL ratio5_period got %0t want 200", last_rise - prev_rise); end
    checks++;
`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
    if (last_high !== 100) begin errors++; $display("FAIL ratio5_high got %0t want 100", last_high); end
`else
    if (last_high !== 120) begin errors++; $display("FAIL ratio5_high got %0t want 120", last_high); end
`endif
  endtask

  task automatic test_ratio_change();
    logic [1:0] o, x;
    int n = 0;
    while (m_pos != m_ratio / 2 + 1 && n < 70) begin
      tick(1'b1, 5, o, x); n++; checks++;
      if (o !== x) begin errors++; $display("FAIL chg_pre cyc %0d got %b want %b", n, o, x); end
    end
    if (n >= 70) begin errors++; $display("FAIL chg_wait timeout got %0d want <70", n); end
    for (int i = 0; i < 14; i++) begin
      tick(1'b1, 3, o, x); checks++;
      if (o !== x) begin errors++; $display("FAIL chg_5to3 cyc %0d got %b want %b", i, o, x); end
    end
    checks++;
    if (last_rise - prev_rise !== 120) begin errors++; $display("FAIL ratio3_period got %0t want 120", last_rise - prev_rise); end
    checks++;
`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
    if (last_high !== 60) begin errors++; $display("FAIL ratio3_high got %0t want 60", last_high); end
`else
    if (last_high !== 80) begin errors++; $display("FAIL ratio3_high got %0t want 80", last_high); end
`endif
  endtask

  task automatic test_even_ratios();
    logic [1:0] o, x;
    int r[2] = '{8, 6};
    int per[2] = '{320, 240};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 26; i++) begin
        tick(1'b1, r[k], o, x); checks++;
        if (o !== x) begin errors++; $display("FAIL even_r%0d cyc %0d got %b want %b", r[k], i, o, x); end
      end
      checks++;
      if (last_rise - prev_rise !== per[k]) begin errors++; $display("FAIL r%0d_period got %0t want %0d", r[k], last_rise - prev_rise, per[k]); end
      checks++;
      if (last_high !== per[k] / 2) begin errors++; $display("FAIL r%0d_high got %0t want %0d", r[k], last_high, per[k] / 2); end
    end
  endtask

  task automatic test_bypass_ratio();
    logic [1:0] o, x;
    int seq[3] = '{1, 0, 4};
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 12; i++) begin
        tick(1'b1, seq[k], o, x); checks++;
        if (o !== x) begin errors++; $display("FAIL bypass_r%0d cyc %0d got %b want %b", seq[k], i, o, x); end
      end
    // By now ratio 0/1 must have put the output straight through for a whole segment.
    checks++;
    if (m_ratio !== 4) begin errors++; $display("FAIL bypass_reentry got ratio %0d want 4", m_ratio); end
  endtask

  task automatic test_enable_drop();
    logic [1:0] o, x;
    int n = 0;
    while (m_pos != 3 && n < 70) begin
      tick(1'b1, 4, o, x); n++; checks++;
      if (o !== x) begin errors++; $display("FAIL en_pre cyc %0d got %b want %b", n, o, x); end
    end
    if (n >= 70) begin errors++; $display("FAIL en_wait timeout got %0d want <70", n); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4, o, x); checks++;
      if (o !== 2'b10) begin errors++; $display("FAIL en_drop cyc %0d got %b want 10", i, o); end
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 4, o, x); checks++;
      if (o !== x) begin errors++; $display("FAIL en_restart cyc %0d got %b want %b", i, o, x); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] o, x;
    int n = 0;
    while (m_pos < m_ratio / 2 + 1 && n < 70) begin
      tick(1'b1, 7, o, x); n++; checks++;
      if (o !== x) begin errors++; $display("FAIL rst_pre cyc %0d got %b want %b", n, o, x); end
    end
    #5 reset = 1'b1;
    #1 checks++;
    if (output_clk !== reference_clk) begin errors++; $display("FAIL rst_mid got %b want %b", output_clk, reference_clk); end
    m_ratio = 0; m_pos = 0;
    @(negedge reference_clk);
    tick(1'b1, 7, o, x); checks++;
    if (o !== 2'b10) begin errors++; $display("FAIL rst_hold got %b want 10", o); end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 7, o, x); checks++;
      if (o !== x) begin errors++; $display("FAIL rst_after cyc %0d got %b want %b", i, o, x); end
    end
  endtask

  task automatic test_random();
    logic [1:0] o, x;
    bit e = 1'b1;
    int r = 9;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 3) e = ~e;
      if ($urandom_range(99) < 8) r = int'($urandom_range(63));
      tick(e, r, o, x); checks++;
      if (o !== x) begin errors++; $display("FAIL random cyc %0d en %0b r %0d got %b want %b", i, e, r, o, x); end
    end
  endtask

  initial begin
    @(negedge reference_clk);
    test_reset();
    test_ratio5();
    test_ratio_change();
    test_even_ratios();
    test_bypass_ratio();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
